// File: rtl/sr_latch_ctrl_pkg.sv
// sr_ctrl_pkg: shared FSM state, op encodings and fixed phase durations for the SR latch controller
package sr_ctrl_pkg;
  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_INIT_GAP = 3'd1,
    S_IDLE     = 3'd2,
    S_DRIVE    = 3'd3,
    S_GAP      = 3'd4,
    S_CHECK    = 3'd5
  } state_e;
  localparam logic OP_CLEAR = 1'b0;
  localparam logic OP_SET = 1'b1;
  localparam int GAP_CYCLES = 1;
  localparam int CHECK_CYCLES = 1;
endpackage

// File: rtl/sr_latch_ctrl_if.sv
// sr_latch_ctrl_if: requester handshake plus latch drive/readback bundle
interface sr_latch_ctrl_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op;
  logic [N_REQ-1:0] ack;
  logic busy;
  logic err;
  logic latch_s_n;
  logic latch_r_n;
  logic latch_q;
  logic latch_qbar;
  modport master (output req, op, latch_q, latch_qbar, input ack, busy, err, latch_s_n, latch_r_n);
  modport slave (input req, op, latch_q, latch_qbar, output ack, busy, err, latch_s_n, latch_r_n);
endinterface

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin pick among requesters; pointer holds the next index to search from
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     en,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr;
  logic [IW-1:0] k;
  // scan downward in offset so the requester closest to the pointer wins
  always_comb begin
    idx = ptr;
    k = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N_REQ);
      if (req[k]) idx = k;
    end
    grant = |req ? (N_REQ'(1) << idx) : '0;
  end
  // advance past the winner only when a grant is actually taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (en && |req) ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: arbitrates set/clear requests onto one NAND SR latch with timed pulses and readback check
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PULSE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  sr_latch_ctrl_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] grant, win;
  logic [IW-1:0] idx;
  logic win_op, win_op_n;
  logic take, done;
  assign take = state == S_IDLE && |bus.req;
  assign done = cnt == CW'(PULSE_CYCLES);
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(bus.req),
    .en(state == S_IDLE),
    .grant(grant),
    .idx(idx)
  );
  // next state, pulse counter and captured op; INIT counts from 0 so the reset cycle adds to the clear pulse
  always_comb begin
    state_n = state;
    case (state)
      S_INIT:     state_n = done ? S_INIT_GAP : S_INIT;
      S_INIT_GAP: state_n = S_IDLE;
      S_IDLE:     state_n = take ? S_DRIVE : S_IDLE;
      S_DRIVE:    state_n = done ? S_GAP : S_DRIVE;
      S_GAP:      state_n = S_CHECK;
      S_CHECK:    state_n = S_IDLE;
      default:    state_n = S_INIT;
    endcase
    cnt_n = (state_n == S_DRIVE && state != S_DRIVE) ? CW'(1) :
            (state_n == state && (state == S_INIT || state == S_DRIVE)) ? cnt + CW'(1) : '0;
    win_op_n = take ? bus.op[idx] : win_op;
  end
  // registered outputs decoded from next state so s_n and r_n can never be low together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      cnt <= '0;
      win <= '0;
      win_op <= OP_CLEAR;
      bus.latch_s_n <= 1'b1;
      bus.latch_r_n <= 1'b0;
      bus.ack <= '0;
      bus.busy <= 1'b1;
      bus.err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      win_op <= win_op_n;
      if (take) win <= grant;
      bus.latch_s_n <= !(state_n == S_DRIVE && win_op_n == OP_SET);
      bus.latch_r_n <= !(state_n == S_INIT || (state_n == S_DRIVE && win_op_n == OP_CLEAR));
      bus.ack <= state_n == S_CHECK ? win : '0;
      bus.busy <= state_n != S_IDLE;
      bus.err <= bus.err | (state == S_GAP && (bus.latch_q != win_op || bus.latch_q == bus.latch_qbar));
    end
  end
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: directed scoreboard bench with a behavioural NAND latch model
module tb_sr_latch_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic stuck = 1'b0;
  logic lq;
  logic got_ack;
  int vectors = 0;
  int miscompares = 0;
  int inv_viol = 0;
  int n;
  typedef struct {
    logic [3:0] ack;
    logic err;
    logic q;
    int lat;
    int sl;
    int rl;
  } exp_t;
  exp_t sb[$];

  sr_latch_ctrl_if #(.N_REQ(4)) bus();
  sr_latch_ctrl #(.N_REQ(4), .PULSE_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(bus.latch_s_n or bus.latch_r_n) begin
    if (bus.latch_s_n === 1'b0) lq = 1'b1;
    else if (bus.latch_r_n === 1'b0) lq = 1'b0;
  end
  assign bus.latch_q = stuck ? 1'b0 : lq;
  assign bus.latch_qbar = ~lq;

  always @(negedge clk) if ((bus.latch_s_n | bus.latch_r_n) !== 1'b1) inv_viol++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic e, input logic q, input int lat, input int sl, input int rl);
    exp_t x;
    x.ack = a;
    x.err = e;
    x.q = q;
    x.lat = lat;
    x.sl = sl;
    x.rl = rl;
    sb.push_back(x);
  endtask

  task automatic run_op(input string tag, input int drop_at);
    int lat, sl, rl;
    logic got;
    exp_t e;
    lat = 0;
    sl = 0;
    rl = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!bus.latch_s_n) sl++;
      if (!bus.latch_r_n) rl++;
      if (lat == drop_at) begin
        bus.req = '0;
        bus.op = ~bus.op;
      end
      if (bus.ack !== 4'b0) got = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, "_ack"}, 32'(bus.ack), 32'(e.ack));
    chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
    chk({tag, "_q"}, 32'(bus.latch_q), 32'(e.q));
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_s_n_low"}, sl, e.sl);
    chk({tag, "_r_n_low"}, rl, e.rl);
    bus.req = bus.req & ~bus.ack;
  endtask

  initial begin
    rst = 1'b0;
    bus.req = '0;
    bus.op = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_s_n", 32'(bus.latch_s_n), 1);
    chk("rst_r_n", 32'(bus.latch_r_n), 0);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init1_r_n", 32'(bus.latch_r_n), 0);
    chk("init1_busy", 32'(bus.busy), 1);
    @(negedge clk);
    chk("init2_r_n", 32'(bus.latch_r_n), 0);
    @(negedge clk);
    chk("init_gap_lines", 32'({bus.latch_s_n, bus.latch_r_n}), 32'b11);
    chk("init_gap_busy", 32'(bus.busy), 1);
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_q", 32'(bus.latch_q), 0);
    chk("idle_err", 32'(bus.err), 0);
    bus.op = 4'b0101;
    bus.req = 4'b1111;
    push(4'b0001, 1'b0, 1'b1, 4, 2, 0);
    push(4'b0010, 1'b0, 1'b0, 5, 0, 2);
    push(4'b0100, 1'b0, 1'b1, 5, 2, 0);
    push(4'b1000, 1'b0, 1'b0, 5, 0, 2);
    repeat (4) run_op("rr", 0);
    @(negedge clk);
    bus.op = 4'b0010;
    bus.req = 4'b0010;
    push(4'b0010, 1'b0, 1'b1, 4, 2, 0);
    run_op("set1", 0);
    @(negedge clk);
    bus.op = 4'b0000;
    bus.req = 4'b0100;
    push(4'b0100, 1'b0, 1'b0, 4, 0, 2);
    run_op("clr2", 0);
    @(negedge clk);
    bus.op = 4'b0000;
    bus.req = 4'b0001;
    push(4'b0001, 1'b0, 1'b0, 4, 0, 2);
    run_op("redundant", 1);
    bus.op = 4'b0000;
    @(negedge clk);
    stuck = 1'b1;
    bus.op = 4'b1000;
    bus.req = 4'b1000;
    push(4'b1000, 1'b1, 1'b0, 4, 2, 0);
    run_op("fault", 0);
    stuck = 1'b0;
    @(negedge clk);
    chk("err_sticky", 32'(bus.err), 1);
    bus.op = 4'b0000;
    bus.req = 4'b0100;
    push(4'b0100, 1'b1, 1'b0, 4, 0, 2);
    run_op("post_fault", 0);
    @(negedge clk);
    bus.op = 4'b0001;
    bus.req = 4'b0001;
    @(negedge clk);
    chk("abort_drive1_s_n", 32'(bus.latch_s_n), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_r_n", 32'(bus.latch_r_n), 0);
    chk("abort_s_n", 32'(bus.latch_s_n), 1);
    chk("abort_busy", 32'(bus.busy), 1);
    chk("abort_err", 32'(bus.err), 0);
    bus.req = '0;
    got_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack !== 4'b0) got_ack = 1'b1;
    end
    rst = 1'b0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.ack !== 4'b0) got_ack = 1'b1;
    end
    chk("abort_idle", 32'(bus.busy), 0);
    chk("abort_no_ack", 32'(got_ack), 0);
    chk("abort_q", 32'(bus.latch_q), 0);
    chk("abort_err_clear", 32'(bus.err), 0);
    chk("never_both_low", inv_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
